// File: rtl/csela_pkg.sv
// csela_pkg: stage-count and stage-boundary helpers for the pipelined carry-select adder
package csela_pkg;

    function automatic int nstg(input int nblk, input int seg);
        return (nblk + seg - 1) / seg;
    endfunction

    function automatic int blk_lo(input int j, input int seg);
        return j * seg;
    endfunction

    function automatic int blk_hi(input int j, input int seg, input int nblk);
        return ((j + 1) * seg < nblk) ? (j + 1) * seg : nblk;
    endfunction

endpackage

// File: rtl/csela_pipe_cselect_block.sv
// cselect_block: one carry-select block, both carry-in sums precomputed then selected
module cselect_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [BLOCK:0]   r0, r1;
    logic [BLOCK-1:0] l0, l1;

    assign r0    = {1'b0, a} + {1'b0, b};
    assign r1    = r0 + {{BLOCK{1'b0}}, 1'b1};
    assign l0    = {1'b0, a[BLOCK-2:0]} + {1'b0, b[BLOCK-2:0]};
    assign l1    = l0 + {{(BLOCK-1){1'b0}}, 1'b1};
    assign s     = cin ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
    assign cout  = cin ? r1[BLOCK] : r0[BLOCK];
    assign c_msb = cin ? l1[BLOCK-1] : l0[BLOCK-1];

endmodule

// File: rtl/csela_pipe.sv
// csela_pipe: stallable pipelined carry-select adder/subtractor with valid/ready on both sides
module csela_pipe
    import csela_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int SEG   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int NSTG = nstg(NBLK, SEG);
    localparam int LAST = NSTG - 1;

    if (WIDTH % BLOCK != 0 || BLOCK < 2) begin : g_bad
        $error("csela_pipe: WIDTH must be a multiple of BLOCK and BLOCK must be >= 2");
    end

    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic [WIDTH-1:0] a_u [NSTG];
    logic [WIDTH-1:0] b_u [NSTG];
    logic [WIDTH-1:0] s_u [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic [NSTG-1:0]  v_q, v_u, cy_q, cy_u, cy_d;
    logic [NSTG:0]    adv;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] sum_all;
    logic [NBLK-1:0]  bc;
    logic             bm [NBLK];

    always_comb begin
        a_u[0]  = a;
        b_u[0]  = b ^ {WIDTH{sub}};
        s_u[0]  = '0;
        cy_u[0] = c ^ sub;
        v_u[0]  = in_valid;
        for (int j = 1; j < NSTG; j++) begin
            a_u[j]  = a_q[j-1];
            b_u[j]  = b_q[j-1];
            s_u[j]  = s_q[j-1];
            cy_u[j] = cy_q[j-1];
            v_u[j]  = v_q[j-1];
        end
    end

    always_comb begin
        adv[NSTG] = out_ready;
        for (int j = NSTG - 1; j >= 0; j--) begin
            adv[j] = adv[j+1] | ~v_q[j];
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        localparam int J = k / SEG;
        logic ci;
        if (k % SEG == 0) begin : g_first
            assign ci = cy_u[J];
        end else begin : g_next
            assign ci = bc[k-1];
        end
        cselect_block #(.BLOCK(BLOCK)) u_blk (
            .a     (a_u[J][k*BLOCK +: BLOCK]),
            .b     (b_u[J][k*BLOCK +: BLOCK]),
            .cin   (ci),
            .s     (sum_all[k*BLOCK +: BLOCK]),
            .cout  (bc[k]),
            .c_msb (bm[k])
        );
    end

    // each stage overwrites only its own bit range of the sum carried down the pipe
    for (genvar j = 0; j < NSTG; j++) begin : g_stg
        localparam int LO = blk_lo(j, SEG) * BLOCK;
        localparam int HI = blk_hi(j, SEG, NBLK) * BLOCK;
        localparam logic [WIDTH-1:0] M = ({WIDTH{1'b1}} >> (WIDTH - HI)) & ({WIDTH{1'b1}} << LO);
        assign s_d[j]  = (s_u[j] & ~M) | (sum_all & M);
        assign cy_d[j] = bc[HI/BLOCK - 1];
    end

    assign ov_d = bc[NBLK-1] ^ bm[NBLK-1];

    always_ff @(posedge clk) begin
        for (int j = 0; j < NSTG; j++) begin
            if (rst) begin
                v_q[j]  <= 1'b0;
                cy_q[j] <= 1'b0;
                a_q[j]  <= '0;
                b_q[j]  <= '0;
                s_q[j]  <= '0;
            end else if (adv[j]) begin
                v_q[j]  <= v_u[j];
                cy_q[j] <= cy_d[j];
                a_q[j]  <= a_u[j];
                b_q[j]  <= b_u[j];
                s_q[j]  <= s_d[j];
            end
        end
        if (rst) begin
            ov_q <= 1'b0;
        end else if (adv[LAST]) begin
            ov_q <= ov_d;
        end
    end

    assign in_ready  = adv[0] & ~rst;
    assign s         = s_q[LAST];
    assign cout      = cy_q[LAST];
    assign ovf       = ov_q;
    assign out_valid = v_q[LAST];

endmodule
